// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: demand-actuated two-approach sequencer with walk.
// Define TPS_NIGHT_FLASH_EN to add the night input and FLASH mode.
module traffic_phase_scheduler #(
   parameter int TICK_DIV  = 50000000,
   parameter int GREEN_MIN = 6,
   parameter int GREEN_MAX = 12,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 1,
   parameter int WALK_T    = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       car_a,
   input  logic       car_b,
   input  logic       ped_req,
`ifdef TPS_NIGHT_FLASH_EN
   input  logic       night,
`endif
   output logic [2:0] light_a,
   output logic [2:0] light_b,
   output logic       walk,
   output logic [2:0] phase,
   output logic [3:0] sec_left,
   output logic       tick
);

   localparam logic [2:0] A_GRN  = 3'd0;
   localparam logic [2:0] A_YEL  = 3'd1;
   localparam logic [2:0] RED_AB = 3'd2;
   localparam logic [2:0] B_GRN  = 3'd3;
   localparam logic [2:0] B_YEL  = 3'd4;
   localparam logic [2:0] RED_BA = 3'd5;
   localparam logic [2:0] WALK   = 3'd6;
   localparam logic [2:0] FLASH  = 3'd7;

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

   localparam logic [3:0] G_MIN = 4'(GREEN_MIN);
   localparam logic [3:0] G_MAX = 4'(GREEN_MAX);
   localparam logic [3:0] Y_T   = 4'(YELLOW_T);
   localparam logic [3:0] AR_T  = 4'(ALLRED_T);
   localparam logic [3:0] W_T   = 4'(WALK_T);

   if (TICK_DIV < 1 || GREEN_MIN > 15 || GREEN_MAX > 15 ||
       YELLOW_T > 15 || ALLRED_T > 15 || WALK_T > 15 ||
       GREEN_MAX < GREEN_MIN) begin : g_param_err
      $error("traffic_phase_scheduler: illegal timing parameter");
   end

   logic [PW-1:0] presc;
   logic [3:0]    elapsed;
   logic [3:0]    el_inc;
   logic [2:0]    state;
   logic [2:0]    nxt;
   logic          wrap;
   logic          ped_pend;
   logic          ret_b;
   logic          flash_on;
   logic          fl_n;
   logic          night_i;
   logic [2:0]    la_n;
   logic [2:0]    lb_n;
   logic          wk_n;

`ifdef TPS_NIGHT_FLASH_EN
   assign night_i = night;
`else
   assign night_i = 1'b0;
`endif

   assign wrap  = (presc == P_LAST);
   assign tick  = wrap;
   assign phase = state;

   // elapsed as it will read after this tick; greens saturate at GREEN_MAX
   always_comb begin
      el_inc = (elapsed == 4'hF) ? 4'hF : elapsed + 4'd1;
      if ((state == A_GRN || state == B_GRN) && el_inc > G_MAX)
         el_inc = G_MAX;
   end

   always_comb begin
      nxt = state;
      if (wrap) begin
         unique case (state)
            A_GRN:
               if ((car_b || ped_pend) &&
                   ((el_inc >= G_MIN && !car_a) || el_inc >= G_MAX))
                  nxt = A_YEL;
            A_YEL:
               if (el_inc >= Y_T) nxt = RED_AB;
            RED_AB:
               if (el_inc >= AR_T)
                  nxt = night_i ? FLASH : (ped_pend ? WALK : B_GRN);
            B_GRN:
               if ((car_a || ped_pend) &&
                   ((el_inc >= G_MIN && !car_b) || el_inc >= G_MAX))
                  nxt = B_YEL;
            B_YEL:
               if (el_inc >= Y_T) nxt = RED_BA;
            RED_BA:
               if (el_inc >= AR_T)
                  nxt = night_i ? FLASH : (ped_pend ? WALK : A_GRN);
            WALK:
               if (el_inc >= W_T) nxt = ret_b ? B_GRN : A_GRN;
            FLASH:
               if (!night_i) nxt = RED_AB;
            default:
               nxt = A_GRN;
         endcase
      end
   end

   always_comb begin
      fl_n = 1'b0;
      if (nxt == FLASH)
         fl_n = (state != FLASH) ? 1'b1 : (wrap ? ~flash_on : flash_on);
   end

   always_comb begin
      la_n = 3'b100;
      lb_n = 3'b100;
      wk_n = 1'b0;
      unique case (nxt)
         A_GRN: la_n = 3'b001;
         A_YEL: la_n = 3'b010;
         B_GRN: lb_n = 3'b001;
         B_YEL: lb_n = 3'b010;
         WALK:  wk_n = 1'b1;
         FLASH: begin
            la_n = fl_n ? 3'b010 : 3'b000;
            lb_n = fl_n ? 3'b100 : 3'b000;
         end
         default: ;
      endcase
   end

   always_comb begin
      sec_left = 4'd0;
      unique case (state)
         A_GRN, B_GRN:
            sec_left = (elapsed >= G_MIN) ? 4'd0 : G_MIN - elapsed;
         A_YEL, B_YEL:   sec_left = Y_T - elapsed;
         RED_AB, RED_BA: sec_left = AR_T - elapsed;
         WALK:           sec_left = W_T - elapsed;
         default:        sec_left = 4'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= A_GRN;
         presc    <= '0;
         elapsed  <= 4'd0;
         ped_pend <= 1'b0;
         ret_b    <= 1'b0;
         flash_on <= 1'b0;
         light_a  <= 3'b001;
         light_b  <= 3'b100;
         walk     <= 1'b0;
      end else begin
         state    <= nxt;
         presc    <= wrap ? '0 : presc + PW'(1);
         flash_on <= fl_n;
         light_a  <= la_n;
         light_b  <= lb_n;
         walk     <= wk_n;
         if (nxt != state)
            elapsed <= 4'd0;
         else if (wrap)
            elapsed <= el_inc;
         // a request on the WALK-entry edge survives the clear
         if (nxt == FLASH || state == FLASH)
            ped_pend <= 1'b0;
         else if (ped_req)
            ped_pend <= 1'b1;
         else if (nxt == WALK && state != WALK)
            ped_pend <= 1'b0;
         if (nxt == WALK && state != WALK)
            ret_b <= (state == RED_AB);
      end
   end

endmodule
